// File: rtl/spi_flash_router.sv
// spi_flash_router
// Oversampled SPI-flash front end. The PCH's SPI pins are brought into the
// clk domain through 2-FF synchronizers and then decoded as mode-0 commands.
// Status, ID and addressing-mode commands are answered locally. READ traffic
// is routed to one of NUM_RAMS PSRAM chips. Page-program data is streamed
// out to a page buffer. Every command is reported to the controller.
//
// Ports
//   clk, reset              system clock (>= 8x spi_clk), async active-high reset
//   spi_clk/cs_in/mosi      raw SPI pins from the PCH
//   spi_miso(_enable)       local response bit and its drive enable
//   ram_sel/ram_read_active selected PSRAM for the READ data mux
//   ram_cs                  per-PSRAM chip select, active low
//   cmd/addr/len_out        last command summary, valid on cmd_strobe
//   byte_out/byte_strobe    every received byte
//   write_data/addr/strobe  page-program data stream
//   sr, sr_in, sr_in_strobe status register and its controller load port
module spi_flash_router #(
    parameter int          NUM_RAMS      = 2,
    parameter int          PAGE_BITS     = 8,
    parameter logic [23:0] JEDEC_ID      = 24'hC22018,
    parameter bit          ADDR4_DEFAULT = 1'b0,
    localparam int         SELW          = (NUM_RAMS <= 2) ? 1 : $clog2(NUM_RAMS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_clk,
    input  logic                 spi_cs_in,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_enable,
    output logic [SELW-1:0]      ram_sel,
    output logic                 ram_read_active,
    output logic [NUM_RAMS-1:0]  ram_cs,
    output logic [7:0]           cmd_out,
    output logic [31:0]          addr_out,
    output logic [11:0]          len_out,
    output logic                 cmd_strobe,
    output logic [7:0]           byte_out,
    output logic                 byte_strobe,
    output logic [7:0]           write_data,
    output logic [PAGE_BITS-1:0] write_addr,
    output logic                 write_strobe,
    output logic [7:0]           sr,
    input  logic [7:0]           sr_in,
    input  logic                 sr_in_strobe
);

    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDS = 8'h04;
    localparam logic [7:0] OP_EN4B = 8'hB7;
    localparam logic [7:0] OP_EX4B = 8'hE9;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_SE   = 8'h20;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_IGNORE} state_t;
    state_t r_state, w_state_next;

    logic [1:0]           r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                 r_sclk_d, r_cs_d;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_shift;
    logic [11:0]          r_len;
    logic [7:0]           r_byte_out;
    logic                 r_byte_strobe;
    logic [7:0]           r_cmd;
    logic [31:0]          r_addr;
    logic [1:0]           r_addr_cnt;
    logic                 r_addr_done;
    logic                 r_wel_dec;
    logic [1:0]           r_id_idx;
    logic [7:0]           r_tx;
    logic                 r_miso, r_miso_en;
    logic [SELW-1:0]      r_ram_sel;
    logic                 r_read_active;
    logic [NUM_RAMS-1:0]  r_ram_cs;
    logic [7:0]           r_cmd_out;
    logic [31:0]          r_addr_out;
    logic [11:0]          r_len_out;
    logic                 r_cmd_strobe;
    logic [7:0]           r_write_data;
    logic [PAGE_BITS-1:0] r_write_addr, r_wptr;
    logic                 r_write_strobe;
    logic [6:0]           r_sr;
    logic                 r_addr4;

    logic                 w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic                 w_active, w_byte_done, w_addr_last;
    logic [7:0]           w_byte, w_sr;
    logic [31:0]          w_addr_shift;
    logic [SELW-1:0]      w_sel;
    logic [NUM_RAMS-1:0]  w_sel_mask;
    logic                 w_unused;

    assign w_sclk_rise  = r_sclk_sync[1] & ~r_sclk_d;
    assign w_sclk_fall  = ~r_sclk_sync[1] & r_sclk_d;
    assign w_cs_fall    = ~r_cs_sync[1] & r_cs_d;
    assign w_cs_rise    = r_cs_sync[1] & ~r_cs_d;
    assign w_active     = (r_state != S_IDLE) && !w_cs_rise;
    assign w_byte       = {r_shift[6:0], r_mosi_sync[1]};
    assign w_byte_done  = w_active && w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_addr_last  = (r_addr_cnt == (r_addr4 ? 2'd3 : 2'd2));
    // 3-byte addresses shift in from zero, so the top byte stays clear.
    assign w_addr_shift = {r_addr[23:0], w_byte};
    assign w_sr         = {r_addr4, r_sr};
    assign w_sel_mask   = NUM_RAMS'(1) << w_sel;
    assign w_unused     = sr_in[7];

    always_comb begin
        w_sel = '0;
        if (NUM_RAMS > 1)
            w_sel = r_addr4 ? w_addr_shift[31 -: SELW] : w_addr_shift[23 -: SELW];
    end

    // Input synchronizers and edge-detect history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], spi_clk};
            r_cs_sync   <= {r_cs_sync[0], spi_cs_in};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
            r_sclk_d    <= r_sclk_sync[1];
            r_cs_d      <= r_cs_sync[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_cs_rise) begin
            w_state_next = S_IDLE;
        end else if (w_cs_fall) begin
            w_state_next = S_CMD;
        end else if (w_byte_done) begin
            case (r_state)
                S_CMD: begin
                    case (w_byte)
                        OP_READ, OP_PP, OP_SE: w_state_next = S_ADDR;
                        OP_RDID, OP_RDSR:      w_state_next = S_DATA;
                        default:               w_state_next = S_IGNORE;
                    endcase
                end
                S_ADDR:  if (w_addr_last) w_state_next = S_DATA;
                default: ;
            endcase
        end
    end

    // Bit engine: partial bytes are dropped on either CS edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'd0;
            r_len         <= 12'd0;
            r_byte_out    <= 8'd0;
            r_byte_strobe <= 1'b0;
        end else begin
            r_byte_strobe <= w_byte_done;
            if (w_byte_done) r_byte_out <= w_byte;
            if (w_cs_fall || w_cs_rise) begin
                r_bit_cnt <= 3'd0;
            end else if (w_active && w_sclk_rise) begin
                r_shift   <= w_byte;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_cs_fall)
                r_len <= 12'd0;
            else if (w_byte_done && r_len != 12'hFFF)
                r_len <= r_len + 12'd1;
        end
    end

    // Command decode, response, routing, write stream and status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd <= 8'd0; r_addr <= 32'd0; r_addr_cnt <= 2'd0; r_addr_done <= 1'b0;
            r_wel_dec <= 1'b0; r_id_idx <= 2'd0; r_tx <= 8'd0;
            r_miso <= 1'b0; r_miso_en <= 1'b0;
            r_ram_sel <= '0; r_read_active <= 1'b0; r_ram_cs <= '1;
            r_cmd_out <= 8'd0; r_addr_out <= 32'd0; r_len_out <= 12'd0; r_cmd_strobe <= 1'b0;
            r_write_data <= 8'd0; r_write_addr <= '0; r_wptr <= '0; r_write_strobe <= 1'b0;
            r_sr <= 7'd0; r_addr4 <= ADDR4_DEFAULT;
        end else begin
            r_cmd_strobe   <= 1'b0;
            r_write_strobe <= 1'b0;
            // MISO trails the tx register by one cycle.
            r_miso         <= r_tx[7];
            if (w_cs_fall) begin
                r_addr <= 32'd0; r_addr_cnt <= 2'd0; r_addr_done <= 1'b0;
                r_ram_cs <= '0; r_tx <= 8'd0;
            end else if (w_cs_rise) begin
                r_miso_en <= 1'b0; r_read_active <= 1'b0; r_ram_cs <= '1;
                r_wptr <= '0; r_write_addr <= '0; r_tx <= 8'd0;
                if (r_state != S_IDLE && r_len != 12'd0) begin
                    r_cmd_out <= r_cmd; r_addr_out <= r_addr; r_len_out <= r_len;
                    r_cmd_strobe <= 1'b1;
                    if ((r_cmd == OP_PP || r_cmd == OP_SE) && r_wel_dec && r_addr_done) begin
                        r_sr[0] <= 1'b1;
                        r_sr[1] <= 1'b0;
                    end
                end
            end else begin
                // The fall right after a byte boundary keeps the freshly loaded MSB on the wire.
                if (w_active && w_sclk_fall && r_bit_cnt != 3'd0)
                    r_tx <= {r_tx[6:0], 1'b0};
                if (w_byte_done) begin
                    case (r_state)
                        S_CMD: begin
                            r_cmd <= w_byte;
                            r_wel_dec <= r_sr[1];
                            if (w_byte != OP_READ) r_ram_cs <= '1;
                            case (w_byte)
                                OP_RDID: begin r_tx <= JEDEC_ID[23:16]; r_id_idx <= 2'd1; r_miso_en <= 1'b1; end
                                OP_RDSR: begin r_tx <= w_sr; r_miso_en <= 1'b1; end
                                OP_WREN: r_sr[1] <= 1'b1;
                                OP_WRDS: r_sr[1] <= 1'b0;
                                OP_EN4B: r_addr4 <= 1'b1;
                                OP_EX4B: r_addr4 <= 1'b0;
                                default: ;
                            endcase
                        end
                        S_ADDR: begin
                            r_addr     <= w_addr_shift;
                            r_addr_cnt <= r_addr_cnt + 2'd1;
                            if (w_addr_last) begin
                                r_addr_done <= 1'b1;
                                if (r_cmd == OP_READ) begin
                                    r_ram_sel     <= w_sel;
                                    r_read_active <= 1'b1;
                                    r_ram_cs      <= ~w_sel_mask;
                                end
                            end
                        end
                        S_DATA: begin
                            if (r_addr_done) r_addr <= r_addr + 32'd1;
                            if (r_cmd == OP_RDID) begin
                                case (r_id_idx)
                                    2'd1:    r_tx <= JEDEC_ID[15:8];
                                    2'd2:    r_tx <= JEDEC_ID[7:0];
                                    default: r_tx <= 8'd0;
                                endcase
                                if (r_id_idx != 2'd3) r_id_idx <= r_id_idx + 2'd1;
                            end
                            if (r_cmd == OP_RDSR) r_tx <= w_sr;
                            if (r_cmd == OP_PP && r_wel_dec) begin
                                r_write_data   <= w_byte;
                                r_write_strobe <= 1'b1;
                                r_write_addr   <= r_wptr;
                                r_wptr         <= r_wptr + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            // Controller load wins over internal WEL/WIP updates.
            if (sr_in_strobe) r_sr <= sr_in[6:0];
        end
    end

    assign spi_miso        = r_miso;
    assign spi_miso_enable = r_miso_en;
    assign ram_sel         = r_ram_sel;
    assign ram_read_active = r_read_active;
    assign ram_cs          = r_ram_cs;
    assign cmd_out         = r_cmd_out;
    assign addr_out        = r_addr_out;
    assign len_out         = r_len_out;
    assign cmd_strobe      = r_cmd_strobe;
    assign byte_out        = r_byte_out;
    assign byte_strobe     = r_byte_strobe;
    assign write_data      = r_write_data;
    assign write_addr      = r_write_addr;
    assign write_strobe    = r_write_strobe;
    assign sr              = w_sr;

endmodule

// File: doc/spi_flash_router.md
# spi_flash_router

Single-clock, oversampled SPI-flash front end for the spispy emulator. Decodes the PCH's mode-0 SPI commands and answers status/ID/mode commands locally. Routes READ traffic to one of `NUM_RAMS` PSRAM chips selected by the top address bits, buffers page-program data, and reports every command to the controller. It generalises the fixed dual-RAM, 24-bit router: parametrised RAM count, page size and JEDEC ID, 3/4-byte addressing (EN4B/EX4B), and a WEL/WIP-correct status register.

## Interface
- `NUM_RAMS`, 2: PSRAM chips; power of two, 1..8; `SELW = max(1, log2(NUM_RAMS))`.
- `PAGE_BITS`, 8: write buffer address width (page = 2^PAGE_BITS bytes).
- `JEDEC_ID`, 24'hC22018: RDID response, MSB first.
- `ADDR4_DEFAULT`, 0: addressing mode after reset (1 = 4-byte).
- `clk` in 1: system clock; must be ≥ 8× spi_clk frequency.
- `reset` in 1: asynchronous, active-high.
- `spi_clk` in 1: raw SPI clock from PCH.
- `spi_cs_in` in 1: raw chip select, active low.
- `spi_mosi` in 1: PCH data in.
- `spi_miso` out 1: local response bit.
- `spi_miso_enable` out 1: drive enable for `spi_miso`.
- `ram_sel` out SELW: RAM whose data is muxed to the PCH during READ.
- `ram_read_active` out 1: high while a READ data phase is in progress.
- `ram_cs` out NUM_RAMS: per-RAM chip select, active low.
- `cmd_out` out 8: last command opcode.
- `addr_out` out 32: last address (upper byte 0 in 3-byte mode).
- `len_out` out 12: bytes in last transaction including opcode.
- `cmd_strobe` out 1: one-cycle pulse; `*_out` valid.
- `byte_out` out 8: every received byte.
- `byte_strobe` out 1: one-cycle pulse per received byte.
- `write_data` out 8: page-program data byte.
- `write_addr` out PAGE_BITS: buffer address.
- `write_strobe` out 1: one-cycle write pulse.
- `sr` out 8: status register; bit0 WIP, bit1 WEL, bit7 ADDR4 (read-only mirror).
- `sr_in` in 8: controller value for bits[6:0].
- `sr_in_strobe` in 1: load `sr[6:0]` from `sr_in`.

## Operation
- Input sync: `spi_clk`, `spi_cs_in` and `spi_mosi` each pass a 2-FF synchronizer; rise/fall detected on synced sclk; CS falling/rising edges detected on synced cs.
- Bit engine: MOSI sampled on sclk rise MSB-first; bit counter 0..7; after the 8th bit the byte completes and `len` increments. `len` is 12 bits and saturates at 4095.
- FSM `IDLE → CMD → ADDR → DATA`, plus `IGNORE`:
  - CS fall: → CMD.
  - CS rise from any state: → IDLE.
  - CMD byte: READ/PP/SE → ADDR. RDID/RDSR → DATA. WREN/WRDS/EN4B/EX4B and unknown opcodes → IGNORE.
  - ADDR: collects `ADDR4 ? 4 : 3` bytes, then → DATA.
- Opcodes:
  - 9F RDID: transmit JEDEC_ID bytes, then 0x00.
  - 05 RDSR: transmit `sr` repeatedly, re-captured at each byte boundary.
  - 06 WREN: WEL=1.
  - 04 WRDS: WEL=0.
  - B7 EN4B: ADDR4=1.
  - E9 EX4B: ADDR4=0.
  - 03 READ: PSRAM routing, below.
  - 02 PP: each DATA byte strobes `write_data`/`write_strobe` at `write_addr`, then increments `write_addr`, wrapping at 2^PAGE_BITS. Bytes are buffered only if WEL was set at opcode decode.
  - 20 SE: no data.
- MISO: the tx byte is loaded at byte completion, and its MSB is driven one cycle later. Shift on each sclk fall. `spi_miso_enable` is high only in DATA for RDID/RDSR.
- RAM routing:
  - CS fall: all `ram_cs` bits follow synced CS (asserted).
  - CMD byte ≠ READ: all `ram_cs` deasserted.
  - READ: all stay asserted through ADDR. After the last address byte, `ram_sel` = top SELW bits of the address (bits [23:] or [31:]), `ram_read_active`=1, and non-selected RAMs are deasserted.
  - Address increments per DATA byte.
- End of command (CS rise, len ≠ 0): latch `*_out` and pulse `cmd_strobe`. If the opcode was PP or SE with WEL set at decode and a complete address: WIP=1, WEL=0.
- `sr_in_strobe`: loads bits[6:0]. On a same-cycle conflict it wins over internal WEL/WIP updates; ADDR4 is never written by it.

## Timing
- Reset values (all outputs):
  - 0: `spi_miso`, `spi_miso_enable`, `ram_read_active`, `ram_sel`, all strobes, `*_out`, `write_*`.
  - `ram_cs` all 1.
  - `sr` = {ADDR4_DEFAULT, 7'b0}.
  - FSM IDLE.
- Bit sample occurs 3 clk after the spi_clk pin rises (2 sync + edge).
- `byte_strobe`: 1 clk after the 8th sample.
- `write_strobe`: same cycle as `byte_strobe`.
- `cmd_strobe`: 3 clk after the CS pin rises.
- CS rise mid-byte: partial bits are discarded and the partial byte is not counted. `miso_enable`, `ram_read_active` and `write_addr` clear on the CS-rise edge cycle.
- Reset mid-transaction: immediate return to reset values; no `cmd_strobe`.

## Test plan
- RDID: CS low, shift 0x9F + 3 dummy bytes → MISO returns C2, 20, 18; `cmd_strobe` with cmd=9F, len=4.
- READ 3-byte, NUM_RAMS=2, addr 0x812345, 2 data bytes:
  - After addr: `ram_sel`=1, `ram_cs`=2'b01.
  - At end: `addr_out`=0x812347, len=6.
- EN4B, then READ 0x00000010: `sr[7]`=1; 4 address bytes consumed; `addr_out` upper byte 0; then EX4B clears `sr[7]`.
- PP without WREN → no `write_strobe`, WIP stays 0.
- WREN + PP with 258 data bytes, PAGE_BITS=8: `write_addr` wraps 255→0; at end sr=0x01 (WIP=1, WEL=0).
- `sr_in_strobe` same cycle as PP completion with `sr_in`=0x00 → `sr[6:0]`=0. Reset asserted mid-READ → `ram_cs` all 1, no `cmd_strobe`.
